// File: rtl/jkff_pkg.sv
// Shared definitions for the JK flip-flop bank: operation encoding and next-state rule.
// Latency: none (types and a pure function only).
// Backpressure: none; consumed by jk_bit and jk_flip_flop.
package jkff_pkg;

    // JK operation as seen on one bit, encoded as {j,k}.
    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_e;

    // Next value of one JK bit given its present value and the sampled j/k.
    function automatic logic next_bit(input logic q, input logic j, input logic k);
        jk_op_e op;
        logic   nq;
        op = jk_op_e'({j, k});
        nq = q;
        case (op)
            HOLD:    nq = q;
            RESET:   nq = 1'b0;
            SET:     nq = 1'b1;
            TOGGLE:  nq = ~q;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_bit.sv
// Single JK storage cell with synchronous clear/preset and an enable gating only the JK action.
// Latency: 1 cycle from sampled j/k/clrn/prn to q.
// Backpressure: none; ce=0 holds q, clear and preset are never gated.
import jkff_pkg::*;

module jk_bit (
    input  logic clk,
    input  logic clrn,
    input  logic prn,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q
);

    // Clear beats preset, preset beats the enabled JK update; toggle uses the pre-edge q.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            q <= 1'b0;
        end else if (!prn) begin
            q <= 1'b1;
        end else if (ce) begin
            q <= next_bit(q, j, k);
        end
    end

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH-bit bank of JK flip-flops with true/complement outputs; optional clock enable under JKFF_CE_EN.
// Latency: 1 cycle from sampled inputs to q; qn is combinational ~q with no extra delay.
// Backpressure: none; with JKFF_CE_EN, ce=0 suppresses JK action while clear/preset still act.
import jkff_pkg::*;

module jk_flip_flop #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             prn,
`ifdef JKFF_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic ce_int;

`ifdef JKFF_CE_EN
    assign ce_int = ce;
`else
    // Without the enable feature the bank updates on every edge.
    assign ce_int = 1'b1;
`endif

    // One independent cell per bit; control inputs are shared across the bank.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit u_bit (
            .clk  (clk),
            .clrn (clrn),
            .prn  (prn),
            .ce   (ce_int),
            .j    (j[i]),
            .k    (k[i]),
            .q    (q[i])
        );
    end

    // Complement is derived from q directly so the pair can never disagree.
    assign qn = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop: a 1-bit and a 4-bit instance share clock and controls.
// Latency: checks are taken on the falling edge after each rising edge.
// Backpressure: none.
module tb_jk_flip_flop;

    logic       clk;
    logic       clrn;
    logic       prn;
    logic       ce;
    logic [0:0] j1, k1, q1, qn1;
    logic [3:0] j4, k4, q4, qn4;

    int tests;
    int fails;

    // Reference state, one per instance.
    logic [3:0] m1;
    logic [3:0] m4;

    jk_flip_flop #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .clrn (clrn),
        .prn  (prn),
`ifdef JKFF_CE_EN
        .ce   (ce),
`endif
        .j    (j1),
        .k    (k1),
        .q    (q1),
        .qn   (qn1)
    );

    jk_flip_flop #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .clrn (clrn),
        .prn  (prn),
`ifdef JKFF_CE_EN
        .ce   (ce),
`endif
        .j    (j4),
        .k    (k4),
        .q    (q4),
        .qn   (qn4)
    );

    // 2 ns clock period.
    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Behavioural rule: clear, then preset, then (if enabled) per-bit JK truth table.
    function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [3:0] j,
                                            input logic [3:0] k, input int w);
        logic [3:0] r;
        r = 4'b0000;
        if (!clrn) return 4'b0000;
        if (!prn) begin
            for (int b = 0; b < w; b++) r[b] = 1'b1;
            return r;
        end
        if (!ce) return q;
        for (int b = 0; b < w; b++) begin
            if (j[b] && k[b])      r[b] = !q[b];
            else if (j[b])         r[b] = 1'b1;
            else if (k[b])         r[b] = 1'b0;
            else                   r[b] = q[b];
        end
        return r;
    endfunction

    // Advance one rising edge, update the models with the inputs seen there, settle to the falling edge.
    task automatic tick();
        @(posedge clk);
        m1 = ref_next(m1, {3'b000, j1}, {3'b000, k1}, 1);
        m4 = ref_next(m4, j4, k4, 4);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare both instances (q and qn) against the models.
    task automatic chk_model(input string tag);
        chk({tag, "_q1"},  {3'b000, q1},  m1);
        chk({tag, "_qn1"}, {3'b000, qn1}, {3'b000, ~m1[0]});
        chk({tag, "_q4"},  q4,  m4);
        chk({tag, "_qn4"}, qn4, ~m4);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m1 = 4'b0000;
        m4 = 4'b0000;
        clrn = 1'b0; prn = 1'b1; ce = 1'b1;
        j1 = 1'b1; k1 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;
        @(negedge clk);

        // Reset with j=k=1: clear must win over toggle.
        tick();
        chk("reset_q",  {3'b000, q1},  4'b0000);
        chk("reset_qn", {3'b000, qn1}, 4'b0001);
        chk("reset_q4", q4, 4'b0000);
        chk("reset_qn4", qn4, 4'b1111);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("reset_hold_q", {3'b000, q1}, 4'b0000);
        end

        // Preset, then clear and preset together.
        clrn = 1'b1; prn = 1'b0; j1 = 1'b0; k1 = 1'b1;
        tick();
        chk("preset_q",  {3'b000, q1},  4'b0001);
        chk("preset_qn", {3'b000, qn1}, 4'b0000);
        chk("preset_q4", q4, 4'b1111);
        clrn = 1'b0; prn = 1'b0;
        tick();
        chk("clr_prio_q",  {3'b000, q1},  4'b0000);
        chk("clr_prio_qn", {3'b000, qn1}, 4'b0001);
        chk("clr_prio_q4", q4, 4'b0000);

        // JK truth table from q=0; the 4-bit bank holds at 0 with j=k=0.
        clrn = 1'b1; prn = 1'b1;
        j1 = 1'b1; k1 = 1'b0; tick(); chk("tt_set",    {3'b000, q1}, 4'b0001);
        j1 = 1'b0; k1 = 1'b0; tick(); chk("tt_hold",   {3'b000, q1}, 4'b0001);
        j1 = 1'b0; k1 = 1'b1; tick(); chk("tt_reset",  {3'b000, q1}, 4'b0000);
        j1 = 1'b1; k1 = 1'b1; tick(); chk("tt_tog1",   {3'b000, q1}, 4'b0001);
                              tick(); chk("tt_tog2",   {3'b000, q1}, 4'b0000);
        chk("tt_q4_held", q4, 4'b0000);

        // Multi-bit: bit3 set, bit2 reset, bit1 toggle, bit0 hold.
        j4 = 4'b1010; k4 = 4'b0110;
        tick(); chk("multi_e1", q4, 4'b1010);
        tick(); chk("multi_e2", q4, 4'b1000);
        tick(); chk("multi_e3", q4, 4'b1010);
        chk_model("multi_model");

        // Free-running: reset on the first edge, j toggles every cycle, k every two.
        clrn = 1'b0; prn = 1'b0; j1 = 1'b0; k1 = 1'b0;
        tick();
        chk_model("free_reset");
        clrn = 1'b1; prn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            j1 = ~j1;
            if (c % 2 == 0) k1 = ~k1;
            j4 = {4{j1[0]}};
            k4 = {4{k1[0]}};
            tick();
            chk_model("free");
        end

        // Randomized operation with occasional clear/preset.
        for (int c = 0; c < 200; c++) begin
            j1   = 1'($urandom);
            k1   = 1'($urandom);
            j4   = 4'($urandom);
            k4   = 4'($urandom);
            clrn = ($urandom_range(0, 15) != 0);
            prn  = ($urandom_range(0, 15) != 0);
`ifdef JKFF_CE_EN
            ce   = 1'($urandom);
`endif
            tick();
            chk_model("rand");
        end

`ifdef JKFF_CE_EN
        // Enable suppresses toggling but never gates clear or preset.
        clrn = 1'b0; prn = 1'b1; ce = 1'b1;
        tick();
        clrn = 1'b1; ce = 1'b0; j1 = 1'b1; k1 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("ce_hold_q1", {3'b000, q1}, 4'b0000);
            chk("ce_hold_q4", q4, 4'b0000);
        end
        clrn = 1'b0;
        tick();
        chk("ce_clr_q1", {3'b000, q1}, 4'b0000);
        clrn = 1'b1; prn = 1'b0;
        tick();
        chk("ce_prn_q1", {3'b000, q1}, 4'b0001);
        chk("ce_prn_q4", q4, 4'b1111);
        chk_model("ce_model");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
